// File: rtl/mant_mult_seq_if.sv
// Operand/product handshake bundle for the sequential mantissa multiplier.
// The producer/consumer side uses the master modport, the multiplier uses slave.
interface mant_mult_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] mant_a;
  logic [23:0] mant_b;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] product;
  logic        busy;

  modport master (
    output in_valid, mant_a, mant_b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, mant_a, mant_b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mant_mult_seq.sv
// Sequential shift-and-add 24x24 -> 48-bit unsigned mantissa multiplier.
// One partial product is folded into the accumulator per clock through a
// single 48-bit ripple-carry adder. The 24x24 product fits 48 bits, so the
// adder needs no carry-out.

// 48-bit ripple-carry adder, carry-out intentionally not exported.
module adder (
  input  logic [47:0] A,
  input  logic [47:0] B,
  output logic [47:0] SUM
);
  logic carry;

  // Bit-serial carry chain from LSB to MSB.
  always_comb begin
    carry = 1'b0;
    SUM   = '0;
    for (int i = 0; i < 48; i++) begin
      SUM[i] = A[i] ^ B[i] ^ carry;
      carry  = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
  end
endmodule

module mant_mult_seq #(
  parameter bit EARLY_TERM = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  mant_mult_seq_if.slave  bus
);
  localparam int DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [2*DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]     mplier;
  logic [2*DATA_W-1:0]   acc;
  logic [4:0]            cnt;
  logic [2*DATA_W-1:0]   addend;
  logic [2*DATA_W-1:0]   sum;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic                  busy_r;
  logic                  last_bit;

  // The multiplicand only contributes when the current multiplier LSB is set.
  always_comb begin
    addend = mplier[0] ? mcand : '0;
  end

  adder u_adder (
    .A   (acc),
    .B   (addend),
    .SUM (sum)
  );

  // Last RUN edge: 24th bit processed, or (early mode) every remaining
  // multiplier bit above the one being added now is zero. Terminating on the
  // upper bits lets the final set bit be accumulated on the same edge, so the
  // run length equals the bit length of mant_b (minimum one edge).
  always_comb begin
    last_bit = (cnt == 5'd23) ||
               (EARLY_TERM && (mplier[DATA_W-1:1] == '0));
  end

  // Control FSM plus datapath registers; handshake outputs are registered
  // alongside the state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand      <= {{DATA_W{1'b0}}, bus.mant_a};
            mplier     <= bus.mant_b;
            acc        <= '0;
            cnt        <= '0;
            state      <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        RUN: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (last_bit) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.product   = acc;
endmodule

// File: tb/tb_mant_mult_seq.sv
// Directed + randomized bench for mant_mult_seq, one instance per EARLY_TERM.
module tb_mant_mult_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mant_mult_seq_if if0 ();
  mant_mult_seq_if if1 ();

  mant_mult_seq #(.EARLY_TERM(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  mant_mult_seq #(.EARLY_TERM(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic        iv  [2];
  logic        orr [2];
  logic [23:0] ma  [2];
  logic [23:0] mb  [2];
  logic        ir  [2];
  logic        ov  [2];
  logic        bsy [2];
  logic [47:0] prod[2];

  assign if0.in_valid = iv[0];  assign if1.in_valid = iv[1];
  assign if0.out_ready = orr[0]; assign if1.out_ready = orr[1];
  assign if0.mant_a = ma[0];    assign if1.mant_a = ma[1];
  assign if0.mant_b = mb[0];    assign if1.mant_b = mb[1];
  assign ir[0] = if0.in_ready;  assign ir[1] = if1.in_ready;
  assign ov[0] = if0.out_valid; assign ov[1] = if1.out_valid;
  assign bsy[0] = if0.busy;     assign bsy[1] = if1.busy;
  assign prod[0] = if0.product; assign prod[1] = if1.product;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic product.
  function automatic logic [47:0] ref_prod(input logic [23:0] a, input logic [23:0] b);
    logic [47:0] wa, wb;
    wa = {24'h0, a};
    wb = {24'h0, b};
    return wa * wb;
  endfunction

  // Reference: RUN edges = 24 in fixed mode, else bit length of b (min 1).
  function automatic int ref_lat(input int s, input logic [23:0] b);
    int n;
    if (s == 0) return 24;
    n = 0;
    for (int i = 0; i < 24; i++) if (b[i]) n = i + 1;
    return (n == 0) ? 1 : n;
  endfunction

  task automatic start_op(input int s, input logic [23:0] a, input logic [23:0] b);
    int w;
    w = 0;
    while (ir[s] !== 1'b1 && w < 10) begin @(posedge clk); #1; w++; end
    check("ready_before_accept", {63'd0, ir[s]}, 64'd1);
    iv[s] = 1'b1; ma[s] = a; mb[s] = b;
    @(posedge clk); #1;
    iv[s] = 1'b0;
    check("ready_low_after_accept", {63'd0, ir[s]}, 64'd0);
    check("busy_after_accept", {63'd0, bsy[s]}, 64'd1);
  endtask

  task automatic wait_done(input int s, input int exp_lat, input logic [47:0] exp_p, input string tag);
    int n;
    bit hs_ok;
    n = 0; hs_ok = 1'b1;
    while (ov[s] !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
      if (ir[s] !== 1'b0 || bsy[s] !== 1'b1) hs_ok = 1'b0;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_product"}, {16'd0, prod[s]}, {16'd0, exp_p});
    check({tag, "_handshake"}, {63'd0, hs_ok}, 64'd1);
  endtask

  task automatic release_out(input int s, input string tag);
    orr[s] = 1'b1;
    @(posedge clk); #1;
    orr[s] = 1'b0;
    check({tag, "_valid_drop"}, {63'd0, ov[s]}, 64'd0);
    check({tag, "_ready_back"}, {63'd0, ir[s]}, 64'd1);
    check({tag, "_busy_drop"}, {63'd0, bsy[s]}, 64'd0);
  endtask

  initial begin
    logic [47:0] held;
    logic [23:0] ra, rb;
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; orr[s] = 1'b0; ma[s] = '0; mb[s] = '0;
    end

    // Reset state
    #12;
    for (int s = 0; s < 2; s++) begin
      check("rst_in_ready", {63'd0, ir[s]}, 64'd1);
      check("rst_out_valid", {63'd0, ov[s]}, 64'd0);
      check("rst_busy", {63'd0, bsy[s]}, 64'd0);
      check("rst_product", {16'd0, prod[s]}, 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: 0x800000 squared, fixed run length
    start_op(0, 24'h800000, 24'h800000);
    wait_done(0, 24, 48'h400000000000, "t1");
    release_out(0, "t1");

    // 2: maximum product and a mixed pattern, both modes
    for (int s = 0; s < 2; s++) begin
      start_op(s, 24'hFFFFFF, 24'hFFFFFF);
      wait_done(s, 24, 48'hFFFFFE000001, "t2max");
      release_out(s, "t2max");
      start_op(s, 24'hC00000, 24'hA00000);
      wait_done(s, 24, 48'h780000000000, "t2mix");
      release_out(s, "t2mix");
    end

    // 3: zero multiplier
    start_op(1, 24'h123456, 24'h000000);
    wait_done(1, 1, 48'h0, "t3_et1");
    release_out(1, "t3_et1");
    start_op(0, 24'h123456, 24'h000000);
    wait_done(0, 24, 48'h0, "t3_et0");
    release_out(0, "t3_et0");

    // 4: backpressure with operand noise
    start_op(0, 24'h9ABCDE, 24'h13579B);
    wait_done(0, 24, ref_prod(24'h9ABCDE, 24'h13579B), "t4");
    held = prod[0];
    for (int k = 0; k < 10; k++) begin
      iv[0] = k[0]; ma[0] = 24'($urandom); mb[0] = 24'($urandom);
      @(posedge clk); #1;
      check("t4_hold_valid", {63'd0, ov[0]}, 64'd1);
      check("t4_hold_product", {16'd0, prod[0]}, {16'd0, held});
      check("t4_hold_ready", {63'd0, ir[0]}, 64'd0);
    end
    iv[0] = 1'b0;
    release_out(0, "t4");

    // 5: reset in the middle of a run
    start_op(0, 24'hABCDEF, 24'h654321);
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_ready", {63'd0, ir[0]}, 64'd1);
    check("t5_rst_valid", {63'd0, ov[0]}, 64'd0);
    check("t5_rst_busy", {63'd0, bsy[0]}, 64'd0);
    check("t5_rst_product", {16'd0, prod[0]}, 64'd0);
    @(negedge clk);
    iv[0] = 1'b1; ma[0] = 24'h000003; mb[0] = 24'h000005;
    rst_n = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    check("t5_accept_first_edge", {63'd0, bsy[0]}, 64'd1);
    wait_done(0, 24, 48'h00000000000F, "t5");
    release_out(0, "t5");

    // 6: back-to-back random operands, 500 per mode
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 500; i++) begin
        ra = 24'($urandom);
        rb = 24'($urandom) >> $urandom_range(0, 24);
        if ((i % 3) == 0) ra[23] = 1'b1;
        start_op(s, ra, rb);
        wait_done(s, ref_lat(s, rb), ref_prod(ra, rb), "t6");
        release_out(s, "t6");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
